// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and sizing helpers for the matrix-multiply controller.
// Holds the controller state enum, accumulator width and address width functions.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Full product width plus one growth bit per doubling of terms summed.
    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + $clog2(k);
    endfunction

    // Address width for a depth of n; a depth of one still gets one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_ctrl_mac_unit.sv
// mac_unit: signed multiply, load/accumulate and output narrowing stage.
// Ports: clk_p/rst_p, issue/first (read issued this cycle, k==0), a_in/b_in
// (operands, valid one cycle after issue), res_data (narrowed accumulator).
// Macro MATMUL_CTRL_SAT_EN selects saturation instead of truncation.
module mac_unit
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 4
) (
    input  logic                         clk_p,
    input  logic                         rst_p,
    input  logic                         issue,
    input  logic                         first,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    output logic signed [DATA_WIDTH-1:0] res_data
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = acc_width(DATA_WIDTH, K);

    logic                 vld_q, vld_d;
    logic                 load_q, load_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;

    // Issue flags are delayed one cycle to line up with the read data.
    always_comb begin
        prod     = a_in * b_in;
        prod_ext = AW'(prod);
        vld_d    = issue;
        load_d   = first;
        acc_d    = acc_q;
        if (vld_q) begin
            acc_d = load_q ? prod_ext : acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            vld_q  <= 1'b0;
            load_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            load_q <= load_d;
            acc_q  <= acc_d;
        end
    end

`ifdef MATMUL_CTRL_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX =
        AW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN =
        AW'(-(64'sd1 <<< (DATA_WIDTH - 1)));

    always_comb begin
        res_data = acc_q[DATA_WIDTH-1:0];
        if (acc_q > SAT_MAX) begin
            res_data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc_q < SAT_MIN) begin
            res_data = SAT_MIN[DATA_WIDTH-1:0];
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^acc_q[AW-1:DATA_WIDTH];

    always_comb begin
        res_data = acc_q[DATA_WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequences an MxK by KxN signed matrix multiply over
// synchronous-read operand memories and a valid/ready result write port.
// Ports: clk_p/rst_p (async active-high), start/busy/done job control,
// m1_*/m2_* operand reads (1-cycle latency), res_* result handshake.
// Macro MATMUL_CTRL_SAT_EN saturates results instead of truncating them.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4
) (
    input  logic                              clk_p,
    input  logic                              rst_p,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              m1_rd_en,
    output logic [addr_width(M*K)-1:0]        m1_addr,
    input  logic signed [DATA_WIDTH-1:0]      m1_rdata,
    output logic                              m2_rd_en,
    output logic [addr_width(K*N)-1:0]        m2_addr,
    input  logic signed [DATA_WIDTH-1:0]      m2_rdata,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [addr_width(M*N)-1:0]        res_addr,
    output logic signed [DATA_WIDTH-1:0]      res_data
);

    localparam int A1W = addr_width(M * K);
    localparam int A2W = addr_width(K * N);
    localparam int ARW = addr_width(M * N);
    localparam int IW  = addr_width(M);
    localparam int JW  = addr_width(N);
    localparam int KW  = addr_width(K);

    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    state_e         state_q, state_d;
    logic [IW-1:0]  i_q, i_d;
    logic [JW-1:0]  j_q, j_d;
    logic [KW-1:0]  k_q, k_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rd_en_q, rd_en_d;
    logic           res_valid_q, res_valid_d;
    logic [A1W-1:0] m1_addr_q, m1_addr_d;
    logic [A2W-1:0] m2_addr_q, m2_addr_d;
    logic [ARW-1:0] res_addr_q, res_addr_d;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                state_d = WRITE;
            end
            WRITE: begin
                if (res_ready) begin
                    k_d = '0;
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        if (i_q == I_LAST) begin
                            state_d = DONE;
                            i_d     = '0;
                        end else begin
                            state_d = RUN;
                            i_d     = i_q + IW'(1);
                        end
                    end else begin
                        state_d = RUN;
                        j_d     = j_q + JW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up
        // with the state they describe.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        rd_en_d     = (state_d == RUN);
        res_valid_d = (state_d == WRITE);
        m1_addr_d   = A1W'(int'(i_d) * K + int'(k_d));
        m2_addr_d   = A2W'(int'(k_d) * N + int'(j_d));
        res_addr_d  = ARW'(int'(i_d) * N + int'(j_d));
    end

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            res_valid_q <= 1'b0;
            m1_addr_q   <= '0;
            m2_addr_q   <= '0;
            res_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            res_valid_q <= res_valid_d;
            m1_addr_q   <= m1_addr_d;
            m2_addr_q   <= m2_addr_d;
            res_addr_q  <= res_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign m1_rd_en  = rd_en_q;
    assign m2_rd_en  = rd_en_q;
    assign m1_addr   = m1_addr_q;
    assign m2_addr   = m2_addr_q;
    assign res_valid = res_valid_q;
    assign res_addr  = res_addr_q;

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .K          (K)
    ) u_mac (
        .clk_p    (clk_p),
        .rst_p    (rst_p),
        .issue    (rd_en_q),
        .first    (rd_en_q && (k_q == '0)),
        .a_in     (m1_rdata),
        .b_in     (m2_rdata),
        .res_data (res_data)
    );

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed element width.
REQ-002 SHALL have parameter M, default 4: rows of matrix1 and of the result.
REQ-003 SHALL have parameter K, default 4: cols of matrix1 = rows of matrix2.
REQ-004 SHALL have parameter N, default 4: cols of matrix2 and of the result.
REQ-005 SHALL have ports: clk_p in 1 clock; rst_p in 1 reset, asynchronous, active-high.
REQ-006 SHALL have ports: start in 1 job request; busy out 1 job active; done out 1 one-cycle completion pulse.
REQ-007 SHALL have ports: m1_rd_en out 1; m1_addr out clog2(M*K); m1_rdata in DATA_WIDTH signed.
REQ-008 SHALL have ports: m2_rd_en out 1; m2_addr out clog2(K*N); m2_rdata in DATA_WIDTH signed.
REQ-009 SHALL have ports: res_valid out 1; res_ready in 1; res_addr out clog2(M*N); res_data out DATA_WIDTH signed.

Function
REQ-010 SHALL use row-major addressing: m1_addr = i*K+k, m2_addr = k*N+j, res_addr = i*N+j.
REQ-011 SHALL have states IDLE, RUN, DRAIN, WRITE, DONE.
REQ-012 SHALL leave IDLE for RUN only when start=1; i, j and k SHALL clear to 0 on that transition.
REQ-013 SHALL ignore start in every state except IDLE.
REQ-014 SHALL assert m1_rd_en and m2_rd_en in RUN for exactly K cycles (k=0..K-1), then go to DRAIN.
REQ-015 SHALL sample operand memories with 1-cycle read latency: rdata is valid the cycle after rd_en.
REQ-016 SHALL form the signed product with full 2*DATA_WIDTH width.
REQ-017 SHALL use accumulator width 2*DATA_WIDTH+clog2(K) so no overflow occurs.
REQ-018 SHALL load (not add) the accumulator with the k=0 product and add each later product.
REQ-019 SHALL accumulate the k=K-1 product during DRAIN (one cycle), then go to WRITE.
REQ-020 SHALL hold res_valid=1 in WRITE with res_addr and res_data stable until res_ready=1.
REQ-021 SHALL, on the res_valid & res_ready cycle: increment j; at j=N-1 wrap j to 0 and increment i; if i=M-1 and j=N-1, go to DONE, else go to RUN with k=0.
REQ-022 SHALL take res_data from the low DATA_WIDTH bits of the accumulator (truncation) when the REQ-034 macro is absent.
REQ-023 SHALL pulse done for exactly one cycle in DONE, then return to IDLE.
REQ-024 SHALL hold busy=1 in RUN, DRAIN, WRITE and DONE, and busy=0 in IDLE.
REQ-025 SHALL produce a job of M*N*(K+2)+1 cycles from start to done with res_ready tied to 1.
REQ-026 SHALL handle K=1: RUN lasts one cycle.
REQ-027 SHALL handle M=N=1: the single WRITE handshake goes directly to DONE.
REQ-028 SHALL keep res_valid, m1_rd_en and m2_rd_en at 0 outside WRITE and RUN respectively.

Reset
REQ-029 SHALL, on rst_p=1 regardless of clock, force state IDLE.
REQ-030 SHALL, on rst_p=1, clear i, j, k and the accumulator to 0.
REQ-031 SHALL, on rst_p=1, drive busy, done, res_valid, m1_rd_en and m2_rd_en to 0.
REQ-032 SHALL, on rst_p=1, drive all address outputs and res_data to 0.
REQ-033 SHALL abandon a job on reset mid-job with no further res_valid; the next job SHALL require a new start.

Configuration
REQ-034 SHALL saturate res_data to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] when MATMUL_CTRL_SAT_EN is defined.
REQ-035 SHALL use plain truncation per REQ-022 when MATMUL_CTRL_SAT_EN is undefined; timing SHALL be identical either way.

Structure
REQ-036 SHALL place the state enum and the accumulator-width function in shared package matmul_pkg.
REQ-037 SHALL instantiate one sub-module, mac_unit, holding the multiply, load/accumulate and the saturate/truncate stage; counters and FSM SHALL stay in matmul_ctrl.

Verification
REQ-038 SHALL cover: M=K=N=2, m1 identity, m2={1,2,3,4}, res_ready=1 -> writes addr0..3 data 1,2,3,4; done at cycle 17 after start.
REQ-039 SHALL cover backpressure: res_ready low 5 cycles at the first WRITE -> res_valid, res_addr=0 and res_data stable throughout; total job 5 cycles longer.
REQ-040 SHALL cover overflow: DATA_WIDTH=8, K=4, all operands 127 -> accumulator 64516; res_data=0x04 without the macro, 127 with MATMUL_CTRL_SAT_EN.
REQ-041 SHALL cover negative saturation: all m1=-128, all m2=127, K=4 -> res_data=-128 with MATMUL_CTRL_SAT_EN.
REQ-042 SHALL cover ignored start: start re-asserted during RUN and during DONE -> no restart, exactly one done pulse.
REQ-043 SHALL cover reset mid-job: rst_p asserted during the second WRITE -> all outputs 0 next cycle; new start yields a complete correct job.
